// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART host-side bus scheduler.
// The optional receive path is built only when UART_SCHED_RX_EN is defined.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        GUARD
    } state_e;

    localparam int BYTE_W  = 8;
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;

    // The guard counter runs 0..cycles-1 and is never narrower than one bit.
    function automatic int guard_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/uart_host_sched_rr.sv
// Combinational round-robin pick: the search starts one past the previous
// grant and wraps, so the last winner has the lowest priority.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      prev_grant,
    output logic               any_valid,
    output logic [IW-1:0]      winner
);
    import uart_sched_pkg::*;

    int            idx;
    logic [IW-1:0] sel;

    always_comb begin
        any_valid = 1'b0;
        winner    = prev_grant;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(prev_grant) + k) % NUM_REQ;
            sel = IW'(idx);
            if (!any_valid && req_valid[sel]) begin
                any_valid = 1'b1;
                winner    = sel;
            end
        end
    end

endmodule

// File: rtl/uart_host_sched.sv
// Owns the UART CSN/WEN/OEN bus: round-robin TX writes, one-entry RX buffer.
// Define UART_SCHED_RX_EN to build the READ path and receive buffer.
module uart_host_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         aresetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         rx_valid,
    output logic [7:0]                   rx_data,
    output logic [1:0]                   rx_err,
    input  logic                         rx_ready,
    output logic                         ovf_sticky,
    input  logic                         clr_ovf,
    output logic                         uart_csn,
    output logic                         uart_wen,
    output logic                         uart_oen,
    output logic [7:0]                   uart_data_in,
    input  logic [7:0]                   uart_data_out,
    input  logic                         uart_txrdy,
    input  logic                         uart_rxrdy,
    input  logic                         uart_parity_err,
    input  logic                         uart_framing_err,
    input  logic                         uart_overflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = guard_w(GUARD_CYCLES);

    state_e              state_q, state_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic                csn_q, csn_d;
    logic                wen_q, wen_d;
    logic                oen_q, oen_d;
    logic [BYTE_W-1:0]   dat_q, dat_d;
    logic [NUM_REQ-1:0]  rdy_q, rdy_d;
    logic [IW-1:0]       gid_q, gid_d;
    logic                ovf_q, ovf_d;
    logic                rx_go;
    logic                arb_any;
    logic [IW-1:0]       arb_win;
    logic [BYTE_W-1:0]   req_byte [NUM_REQ];

`ifdef UART_SCHED_RX_EN
    logic                rx_cap;
    logic                rxv_q;
    logic [BYTE_W-1:0]   rxd_q;
    logic [1:0]          rxe_q;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
        assign req_byte[i] = req_data[8*i +: 8];
    end

    uart_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req_valid  (req_valid),
        .prev_grant (gid_q),
        .any_valid  (arb_any),
        .winner     (arb_win)
    );

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        csn_d   = 1'b1;
        wen_d   = 1'b1;
        oen_d   = 1'b1;
        rdy_d   = '0;
        dat_d   = dat_q;
        gid_d   = gid_q;
`ifdef UART_SCHED_RX_EN
        rx_cap  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // RX wins so the UART receive holding register drains first
                if (rx_go) begin
                    state_d = READ;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (arb_any && uart_txrdy) begin
                    state_d = WRITE;
                    csn_d   = 1'b0;
                    wen_d   = 1'b0;
                    rdy_d   = NUM_REQ'(1) << arb_win;
                    dat_d   = req_byte[arb_win];
                    gid_d   = arb_win;
                end
            end
            WRITE: begin
                state_d = GUARD;
                gcnt_d  = '0;
            end
`ifdef UART_SCHED_RX_EN
            READ: begin
                state_d = GUARD;
                gcnt_d  = '0;
                rx_cap  = 1'b1;
            end
`endif
            GUARD: begin
                if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovf_d = uart_overflow | (ovf_q & ~clr_ovf);

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            dat_q   <= '0;
            rdy_q   <= '0;
            gid_q   <= IW'(NUM_REQ - 1);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            csn_q   <= csn_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            dat_q   <= dat_d;
            rdy_q   <= rdy_d;
            gid_q   <= gid_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UART_SCHED_RX_EN
    assign rx_go = uart_rxrdy && !rxv_q;

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            rxv_q <= 1'b0;
            rxd_q <= '0;
            rxe_q <= '0;
        end else if (rx_cap) begin
            rxv_q          <= 1'b1;
            rxd_q          <= uart_data_out;
            rxe_q[ERR_FRM] <= uart_framing_err;
            rxe_q[ERR_PAR] <= uart_parity_err;
        end else if (rxv_q && rx_ready) begin
            rxv_q <= 1'b0;
        end
    end

    assign rx_valid = rxv_q;
    assign rx_data  = rxd_q;
    assign rx_err   = rxe_q;
`else
    logic unused_rx;

    assign rx_go     = 1'b0;
    assign rx_valid  = 1'b0;
    assign rx_data   = '0;
    assign rx_err    = '0;
    assign unused_rx = ^{uart_rxrdy, uart_data_out, uart_parity_err,
                         uart_framing_err, rx_ready};
`endif

    assign uart_csn     = csn_q;
    assign uart_wen     = wen_q;
    assign uart_oen     = oen_q;
    assign uart_data_in = dat_q;
    assign req_ready    = rdy_q;
    assign grant_id     = gid_q;
    assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_uart_host_sched.sv
// Bench for uart_host_sched: directed table, RX corner sequences, reset
// mid-strobe, then random traffic against a timeline-based reference model.
module tb_uart_host_sched;

    localparam int NUM_REQ = 4;
    localparam int G       = 2;
`ifdef UART_SCHED_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic                 CLK;
    logic                 aresetn;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [1:0]           grant_id;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic [1:0]           rx_err;
    logic                 rx_ready;
    logic                 ovf_sticky;
    logic                 clr_ovf;
    logic                 uart_csn, uart_wen, uart_oen;
    logic [7:0]           uart_data_in;
    logic [7:0]           uart_data_out;
    logic                 uart_txrdy, uart_rxrdy;
    logic                 uart_parity_err, uart_framing_err, uart_overflow;

    uart_host_sched #(
        .NUM_REQ          (NUM_REQ),
        .GUARD_CYCLES     (G)
    ) dut (
        .CLK              (CLK),
        .aresetn          (aresetn),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .grant_id         (grant_id),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_err           (rx_err),
        .rx_ready         (rx_ready),
        .ovf_sticky       (ovf_sticky),
        .clr_ovf          (clr_ovf),
        .uart_csn         (uart_csn),
        .uart_wen         (uart_wen),
        .uart_oen         (uart_oen),
        .uart_data_in     (uart_data_in),
        .uart_data_out    (uart_data_out),
        .uart_txrdy       (uart_txrdy),
        .uart_rxrdy       (uart_rxrdy),
        .uart_parity_err  (uart_parity_err),
        .uart_framing_err (uart_framing_err),
        .uart_overflow    (uart_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: the bus is free again 2+G cycles after a decision.
    int         m_idle_at;
    int         m_last;
    logic       m_csn, m_wen, m_oen, m_rxv, m_ovf;
    logic [3:0] m_rdy;
    logic [7:0] m_din, m_rxd;
    logic [1:0] m_rxe;

    typedef struct packed {
        logic [3:0] rv;
        logic       tx;
        logic       ovf;
        logic       clr;
        logic [3:0] e_rdy;
        logic [7:0] e_din;
        logic [1:0] e_gid;
        logic       e_ovf;
    } vec_t;

    vec_t tv [30];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_csn     = 1'b1;
        m_wen     = 1'b1;
        m_oen     = 1'b1;
        m_rdy     = '0;
        m_din     = '0;
        m_last    = NUM_REQ - 1;
        m_rxv     = 1'b0;
        m_rxd     = '0;
        m_rxe     = '0;
        m_ovf     = 1'b0;
        m_idle_at = 0;
    endfunction

    task automatic model_step();
        logic       ncsn, nwen, noen, nrxv;
        logic [3:0] nrdy;
        logic [7:0] nrxd;
        logic [1:0] nrxe;
        bit         found;
        ncsn  = 1'b1;
        nwen  = 1'b1;
        noen  = 1'b1;
        nrdy  = '0;
        found = 1'b0;
        nrxv  = m_rxv && !rx_ready;
        nrxd  = m_rxd;
        nrxe  = m_rxe;
        if (!m_oen) begin
            nrxv = 1'b1;
            nrxd = uart_data_out;
            nrxe = {uart_framing_err, uart_parity_err};
        end
        if (cyc >= m_idle_at) begin
            if (RX_EN && uart_rxrdy && !m_rxv) begin
                ncsn      = 1'b0;
                noen      = 1'b0;
                m_idle_at = cyc + 2 + G;
            end else if (uart_txrdy) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int j;
                    j = (m_last + k) % NUM_REQ;
                    if (!found && req_valid[j]) begin
                        found     = 1'b1;
                        m_last    = j;
                        m_din     = req_data[8*j +: 8];
                        nrdy[j]   = 1'b1;
                        ncsn      = 1'b0;
                        nwen      = 1'b0;
                        m_idle_at = cyc + 2 + G;
                    end
                end
            end
        end
        m_ovf = uart_overflow | (m_ovf & ~clr_ovf);
        m_csn = ncsn;
        m_wen = nwen;
        m_oen = noen;
        m_rdy = nrdy;
        m_rxv = nrxv;
        m_rxd = nrxd;
        m_rxe = nrxe;
    endtask

    task automatic check_all();
        chk("csn", uart_csn, m_csn);
        chk("wen", uart_wen, m_wen);
        chk("oen", uart_oen, m_oen);
        chk("req_ready", req_ready, m_rdy);
        chk("data_in", uart_data_in, m_din);
        chk("grant_id", grant_id, m_last);
        chk("rx_valid", rx_valid, m_rxv);
        chk("rx_data", rx_data, m_rxd);
        chk("rx_err", rx_err, m_rxe);
        chk("ovf_sticky", ovf_sticky, m_ovf);
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        check_all();
    endtask

    function automatic vec_t row(input logic [3:0] rv, input logic tx,
                                 input logic [3:0] e_rdy,
                                 input logic [7:0] e_din,
                                 input logic [1:0] e_gid);
        vec_t v;
        v       = '0;
        v.rv    = rv;
        v.tx    = tx;
        v.e_rdy = e_rdy;
        v.e_din = e_din;
        v.e_gid = e_gid;
        return v;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] pend, rdy_seen;
        logic [7:0] pdata [NUM_REQ];
        int n_oen, n_wen, k;
        bit got;

        aresetn          = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        rx_ready         = 1'b0;
        clr_ovf          = 1'b0;
        uart_data_out    = '0;
        uart_txrdy       = 1'b0;
        uart_rxrdy       = 1'b0;
        uart_parity_err  = 1'b0;
        uart_framing_err = 1'b0;
        uart_overflow    = 1'b0;
        model_reset();

        // Fairness, single TX, backpressure, overflow set/clear.
        for (int i = 0; i < 30; i++) tv[i] = row(4'b1111, 1'b1, 4'b0, 8'h0, 2'd0);
        tv[0]  = row(4'b1111, 1'b1, 4'b0001, 8'hC0, 2'd0);
        tv[4]  = row(4'b1111, 1'b1, 4'b0010, 8'hB1, 2'd1);
        tv[8]  = row(4'b1111, 1'b1, 4'b0100, 8'hA5, 2'd2);
        tv[12] = row(4'b1111, 1'b1, 4'b1000, 8'hD3, 2'd3);
        tv[16] = row(4'b1111, 1'b1, 4'b0001, 8'hC0, 2'd0);
        for (int i = 17; i < 20; i++) tv[i] = row(4'b0100, 1'b1, 4'b0, 8'h0, 2'd0);
        tv[20] = row(4'b0100, 1'b1, 4'b0100, 8'hA5, 2'd2);
        for (int i = 21; i < 26; i++) tv[i] = row(4'b0010, 1'b0, 4'b0, 8'h0, 2'd0);
        tv[26] = row(4'b0010, 1'b1, 4'b0010, 8'hB1, 2'd1);
        for (int i = 27; i < 30; i++) tv[i] = row(4'b0000, 1'b1, 4'b0, 8'h0, 2'd0);
        tv[27].ovf   = 1'b1;
        tv[27].clr   = 1'b1;
        tv[27].e_ovf = 1'b1;
        tv[28].clr   = 1'b1;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_csn", uart_csn, 1);
        chk("rst_wen", uart_wen, 1);
        chk("rst_oen", uart_oen, 1);
        chk("rst_data_in", uart_data_in, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, NUM_REQ - 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_ovf", ovf_sticky, 0);
        aresetn = 1'b1;

        req_data = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
        for (int i = 0; i < 30; i++) begin
            req_valid     = tv[i].rv;
            uart_txrdy    = tv[i].tx;
            uart_overflow = tv[i].ovf;
            clr_ovf       = tv[i].clr;
            cycle();
            chk("tbl_ready", req_ready, tv[i].e_rdy);
            chk("tbl_wen", uart_wen, tv[i].e_rdy == 4'b0);
            chk("tbl_ovf", ovf_sticky, tv[i].e_ovf);
            if (tv[i].e_rdy != 4'b0) begin
                chk("tbl_data_in", uart_data_in, tv[i].e_din);
                chk("tbl_grant", grant_id, tv[i].e_gid);
            end
        end
        uart_overflow = 1'b0;
        clr_ovf       = 1'b0;

        // RX priority over a pending write, and error capture.
        req_valid       = 4'b0001;
        uart_txrdy      = 1'b1;
        uart_rxrdy      = 1'b1;
        uart_data_out   = 8'h3C;
        uart_parity_err = 1'b1;
        rx_ready        = 1'b0;
        cycle();
`ifdef UART_SCHED_RX_EN
        chk("rxpri_oen", uart_oen, 0);
        chk("rxpri_wen", uart_wen, 1);
`else
        chk("norx_oen", uart_oen, 1);
        chk("norx_wen", uart_wen, 0);
`endif
        uart_rxrdy = 1'b0;
        cycle();
`ifdef UART_SCHED_RX_EN
        chk("rxcap_valid", rx_valid, 1);
        chk("rxcap_data", rx_data, 8'h3C);
        chk("rxcap_err", rx_err, 2'b01);
`else
        chk("norx_valid", rx_valid, 0);
`endif

        // Buffer full: no reads, writes keep flowing.
        uart_parity_err = 1'b0;
        uart_data_out   = 8'h77;
        uart_rxrdy      = 1'b1;
        n_oen = 0;
        n_wen = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (!uart_oen) n_oen++;
            if (!uart_wen) n_wen++;
        end
        chk("full_no_read", n_oen, 0);
        chk("full_writes", n_wen, 4);

        rx_ready = 1'b1;
        cycle();
        rx_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!uart_oen) got = 1'b1;
        end
`ifdef UART_SCHED_RX_EN
        chk("drain_read", got, 1);
        chk("drain_data", rx_data, 8'h77);
`else
        chk("norx_read", got, 0);
`endif

        // Asynchronous reset while a write strobe is on the bus.
        uart_rxrdy = 1'b0;
        rx_ready   = 1'b1;
        req_valid  = 4'b0001;
        k = 0;
        while (m_wen && k < 10) begin
            cycle();
            k++;
        end
        chk("pre_rst_wen", uart_wen, 0);
        aresetn = 1'b0;
        #1;
        chk("arst_csn", uart_csn, 1);
        chk("arst_wen", uart_wen, 1);
        chk("arst_oen", uart_oen, 1);
        chk("arst_ready", req_ready, 0);
        chk("arst_grant", grant_id, NUM_REQ - 1);
        chk("arst_rx_valid", rx_valid, 0);
        model_reset();
        @(posedge CLK);
        #1;
        aresetn = 1'b1;

        // Random traffic respecting the hold-until-ready requester rule.
        pend     = '0;
        rdy_seen = '0;
        for (int i = 0; i < NUM_REQ; i++) pdata[i] = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rdy_seen[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 99) < 30) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
            end
            rdy_seen         = m_rdy;
            req_valid        = pend;
            req_data         = {pdata[3], pdata[2], pdata[1], pdata[0]};
            uart_txrdy       = $urandom_range(0, 99) < 70;
            uart_rxrdy       = $urandom_range(0, 99) < 30;
            uart_data_out    = 8'($urandom);
            uart_parity_err  = 1'($urandom);
            uart_framing_err = 1'($urandom);
            rx_ready         = $urandom_range(0, 99) < 50;
            uart_overflow    = $urandom_range(0, 99) < 5;
            clr_ovf          = $urandom_range(0, 99) < 10;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
